// File: rtl/parallel_to_serial_mlane_if.sv
// Handshake and serial-output bundle for parallel_to_serial_mlane.
// The slave side is the converter and the master side is its producer/consumer.
interface parallel_to_serial_mlane_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1
);
    logic [DATA_WIDTH-1:0] din_parallel;
    logic                  din_msb_first;
    logic                  din_valid;
    logic                  din_ready;
    logic                  shift_en;
    logic [LANES-1:0]      dout_serial;
    logic                  dout_valid;
    logic                  dout_last;
    logic                  busy;

    modport slave (
        input  din_parallel, din_msb_first, din_valid, shift_en,
        output din_ready, dout_serial, dout_valid, dout_last, busy
    );

    modport master (
        output din_parallel, din_msb_first, din_valid, shift_en,
        input  din_ready, dout_serial, dout_valid, dout_last, busy
    );
endinterface

// File: rtl/parallel_to_serial_mlane.sv
// Multi-lane parallel-to-serial converter with a one-word holding buffer behind the
// shift register, so back-to-back words stream without an idle beat.
module parallel_to_serial_mlane #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    parallel_to_serial_mlane_if.slave  bus
);
    localparam int                   BEATS    = DATA_WIDTH / LANES;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BEATS - 1);

    // The word is never physically shifted; the beat counter selects the slice.
    // An MSB-first beat is the natural descending slice, so its earlier bit sits in the top lane.
    function automatic logic [LANES-1:0] beat_sel(input logic [DATA_WIDTH-1:0] word,
                                                  input logic                  msb_first,
                                                  input logic [CNT_WIDTH-1:0]  k);
        logic [DATA_WIDTH-1:0] sh;
        int                    base;
        if (msb_first) base = DATA_WIDTH - (int'(k) + 1) * LANES;
        else           base = int'(k) * LANES;
        sh = word >> base;
        return sh[LANES-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] sreg_q, sreg_d, hold_q, hold_d;
    logic                  sreg_msb_q, sreg_msb_d, hold_msb_q, hold_msb_d;
    logic                  sreg_valid_q, sreg_valid_d, hold_valid_q, hold_valid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LANES-1:0]      dout_serial_q, dout_serial_d;
    logic                  dout_valid_q, dout_valid_d, dout_last_q, dout_last_d;
    logic                  accept, shift, last_beat;

    assign accept    = bus.din_valid && !hold_valid_q;
    assign shift     = sreg_valid_q && bus.shift_en;
    assign last_beat = shift && (cnt_q == LAST_CNT);

    always_comb begin
        sreg_d        = sreg_q;
        sreg_msb_d    = sreg_msb_q;
        sreg_valid_d  = sreg_valid_q;
        hold_d        = hold_q;
        hold_msb_d    = hold_msb_q;
        hold_valid_d  = hold_valid_q;
        cnt_d         = cnt_q;
        dout_serial_d = '0;
        dout_valid_d  = shift;
        dout_last_d   = last_beat;

        if (shift) begin
            dout_serial_d = beat_sel(sreg_q, sreg_msb_q, cnt_q);
            cnt_d         = last_beat ? '0 : cnt_q + CNT_WIDTH'(1);
        end

        // An empty sreg implies an empty hold, so hold only matters on a last beat.
        if (!sreg_valid_q || last_beat) begin
            if (hold_valid_q) begin
                sreg_d       = hold_q;
                sreg_msb_d   = hold_msb_q;
                sreg_valid_d = 1'b1;
                hold_valid_d = 1'b0;
            end else if (accept) begin
                sreg_d       = bus.din_parallel;
                sreg_msb_d   = bus.din_msb_first;
                sreg_valid_d = 1'b1;
            end else begin
                sreg_valid_d = 1'b0;
            end
        end else if (accept) begin
            hold_d       = bus.din_parallel;
            hold_msb_d   = bus.din_msb_first;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        sreg_q     <= sreg_d;
        sreg_msb_q <= sreg_msb_d;
        hold_q     <= hold_d;
        hold_msb_q <= hold_msb_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_valid_q  <= 1'b0;
            hold_valid_q  <= 1'b0;
            cnt_q         <= '0;
            dout_serial_q <= '0;
            dout_valid_q  <= 1'b0;
            dout_last_q   <= 1'b0;
        end else begin
            sreg_valid_q  <= sreg_valid_d;
            hold_valid_q  <= hold_valid_d;
            cnt_q         <= cnt_d;
            dout_serial_q <= dout_serial_d;
            dout_valid_q  <= dout_valid_d;
            dout_last_q   <= dout_last_d;
        end
    end

    assign bus.din_ready   = !hold_valid_q;
    assign bus.busy        = sreg_valid_q | hold_valid_q;
    assign bus.dout_serial = dout_serial_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.dout_last   = dout_last_q;
endmodule

// File: tb/tb_parallel_to_serial_mlane.sv
// Bench for parallel_to_serial_mlane: single-lane and two-lane instances, directed
// scenarios plus random traffic against a word-queue reference model.
module tb_parallel_to_serial_mlane;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parallel_to_serial_mlane_if #(.DATA_WIDTH(8), .LANES(1)) bus1 ();
    parallel_to_serial_mlane_if #(.DATA_WIDTH(8), .LANES(2)) bus2 ();

    parallel_to_serial_mlane #(.DATA_WIDTH(8), .LANES(1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));
    parallel_to_serial_mlane #(.DATA_WIDTH(8), .LANES(2), .CNT_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference beat: the k-th group of L bits counted from the chosen end of the word.
    function automatic int beat_of(input logic [7:0] word, input bit msb, input int k, input int l);
        int w;
        w = int'(word);
        if (msb) return (w >> (8 - (k + 1) * l)) & ((1 << l) - 1);
        return (w >> (k * l)) & ((1 << l) - 1);
    endfunction

    // Reference model for the single-lane instance: queue of words still owed beats.
    logic [7:0] mq_word[$];
    bit         mq_msb[$];
    int         mpos = 0;
    logic       exp_serial = 1'b0;
    bit         exp_valid  = 1'b0;
    bit         exp_last   = 1'b0;
    bit         acc;

    task automatic step1(input bit v, input logic [7:0] d, input bit msb, input bit se, output bit a);
        bus1.din_valid     = v;
        bus1.din_parallel  = d;
        bus1.din_msb_first = msb;
        bus1.shift_en      = se;
        a = v && (mq_word.size() < 2);
        @(posedge clk);
        if (rst) begin
            mq_word.delete();
            mq_msb.delete();
            mpos = 0;
            exp_serial = 1'b0; exp_valid = 1'b0; exp_last = 1'b0;
            a = 1'b0;
        end else begin
            if (se && mq_word.size() > 0) begin
                exp_serial = 1'(beat_of(mq_word[0], mq_msb[0], mpos, 1));
                exp_valid  = 1'b1;
                exp_last   = (mpos == 7);
                mpos++;
                if (mpos == 8) begin
                    void'(mq_word.pop_front());
                    void'(mq_msb.pop_front());
                    mpos = 0;
                end
            end else begin
                exp_serial = 1'b0; exp_valid = 1'b0; exp_last = 1'b0;
            end
            if (a) begin
                mq_word.push_back(d);
                mq_msb.push_back(msb);
            end
        end
        #1;
        check("dout_valid",  32'(bus1.dout_valid),  32'(exp_valid));
        check("dout_serial", 32'(bus1.dout_serial), 32'(exp_serial));
        check("dout_last",   32'(bus1.dout_last),   32'(exp_last));
        check("din_ready",   32'(bus1.din_ready),   32'(mq_word.size() < 2));
        check("busy",        32'(bus1.busy),        32'(mq_word.size() > 0));
    endtask

    task automatic step2(input bit v, input logic [7:0] d, input bit msb, input bit se);
        bus2.din_valid     = v;
        bus2.din_parallel  = d;
        bus2.din_msb_first = msb;
        bus2.shift_en      = se;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] col;
        logic [7:0] words[3];
        int         idx, run, max_run, lasts, nready;
        int         beats2[4], lasts2[4];

        bus1.din_valid = 1'b0; bus1.din_parallel = '0; bus1.din_msb_first = 1'b0; bus1.shift_en = 1'b0;
        bus2.din_valid = 1'b0; bus2.din_parallel = '0; bus2.din_msb_first = 1'b0; bus2.shift_en = 1'b0;

        // Reset state
        rst = 1'b1;
        step1(0, 8'h00, 0, 1, acc);
        step1(0, 8'h00, 0, 1, acc);
        check("rst_ready2", 32'(bus2.din_ready), 32'd1);
        check("rst_busy2",  32'(bus2.busy),      32'd0);
        rst = 1'b0;
        step1(0, 8'h00, 0, 1, acc);

        // MSB-first 8'hA5 on one lane
        step1(1, 8'hA5, 1, 1, acc);
        check("t1_accept", 32'(acc), 32'd1);
        col = '0;
        for (int i = 0; i < 8; i++) begin
            step1(0, 8'h00, 0, 1, acc);
            col = {col[6:0], bus1.dout_serial};
        end
        check("t1_bits", 32'(col), 32'hA5);
        check("t1_last", 32'(bus1.dout_last), 32'd1);
        step1(0, 8'h00, 0, 1, acc);

        // LSB-first 8'hA5 (palindrome) then 8'h01
        step1(1, 8'hA5, 0, 1, acc);
        col = '0;
        for (int i = 0; i < 8; i++) begin
            step1(0, 8'h00, 0, 1, acc);
            col = {col[6:0], bus1.dout_serial};
        end
        check("t2_bits_a5", 32'(col), 32'hA5);
        step1(1, 8'h01, 0, 1, acc);
        col = '0;
        for (int i = 0; i < 8; i++) begin
            step1(0, 8'h00, 0, 1, acc);
            col = {col[6:0], bus1.dout_serial};
        end
        check("t2_bits_01", 32'(col), 32'h80);
        step1(0, 8'h00, 0, 1, acc);

        // Two lanes, 8'hB4 MSB-first then LSB-first
        for (int pass = 0; pass < 2; pass++) begin
            step2(1, 8'hB4, pass == 0, 1);
            for (int i = 0; i < 4; i++) begin
                step2(0, 8'h00, 0, 1);
                beats2[i] = (bus2.dout_valid === 1'b1) ? int'(bus2.dout_serial) : -1;
                lasts2[i] = int'(bus2.dout_last);
            end
            for (int i = 0; i < 4; i++) begin
                check(pass == 0 ? "t3_msb_beat" : "t3_lsb_beat", 32'(beats2[i]),
                      32'(beat_of(8'hB4, pass == 0, i, 2)));
                check("t3_last", 32'(lasts2[i]), 32'(i == 3));
            end
            step2(0, 8'h00, 0, 1);
            check("t3_idle_valid", 32'(bus2.dout_valid), 32'd0);
        end
        check("t3_msb_b0", 32'(beat_of(8'hB4, 1, 0, 2)), 32'd2);

        // Three words back-to-back: one unbroken run of 24 valid beats
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        idx = 0; run = 0; max_run = 0; nready = 0;
        for (int c = 0; c < 40; c++) begin
            step1(idx < 3, words[idx < 3 ? idx : 2], 1, 1, acc);
            if (acc) idx++;
            if (bus1.din_ready === 1'b0) nready++;
            if (bus1.dout_valid === 1'b1) run++; else run = 0;
            if (run > max_run) max_run = run;
        end
        check("t4_accepted", 32'(idx), 32'd3);
        check("t4_run", 32'(max_run), 32'd24);
        check("t4_not_ready_seen", 32'(nready > 0), 32'd1);

        // Stall three cycles after beat 3 of 8'hC3
        step1(1, 8'hC3, 1, 1, acc);
        col = '0;
        for (int i = 0; i < 3; i++) begin
            step1(0, 8'h00, 0, 1, acc);
            col = {col[6:0], bus1.dout_serial};
        end
        for (int i = 0; i < 3; i++) begin
            step1(0, 8'h00, 0, 0, acc);
            check("t5_stall_valid", 32'(bus1.dout_valid), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            step1(0, 8'h00, 0, 1, acc);
            col = {col[6:0], bus1.dout_serial};
        end
        check("t5_bits", 32'(col), 32'hC3);
        check("t5_last", 32'(bus1.dout_last), 32'd1);
        step1(0, 8'h00, 0, 1, acc);

        // Reset at beat 5 with hold full
        step1(1, 8'h5A, 1, 1, acc);
        step1(1, 8'h3C, 1, 1, acc);
        check("t6_hold_ready", 32'(bus1.din_ready), 32'd0);
        for (int i = 0; i < 3; i++) step1(0, 8'h00, 0, 1, acc);
        rst = 1'b1;
        step1(0, 8'h00, 0, 1, acc);
        rst = 1'b0;
        check("t6_valid", 32'(bus1.dout_valid), 32'd0);
        check("t6_last",  32'(bus1.dout_last),  32'd0);
        check("t6_ready", 32'(bus1.din_ready),  32'd1);
        check("t6_busy",  32'(bus1.busy),       32'd0);
        lasts = 0;
        for (int i = 0; i < 12; i++) begin
            step1(0, 8'h00, 0, 1, acc);
            if (bus1.dout_last === 1'b1) lasts++;
        end
        check("t6_no_last", 32'(lasts), 32'd0);

        // Random traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            step1(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, acc);
        end
        for (int c = 0; c < 20; c++) step1(0, 8'h00, 0, 1, acc);
        check("rand_drained_busy", 32'(bus1.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
